run_feeder: RTL and testbench

//   Producer end of the merger input-FIFO interface. Takes one tuple per cycle from an upstream
//   run source (valid/ready) and packs P tuples into one wide word, lane 0 = first tuple.

---
 rtl/run_feeder.sv | 186 ++++++++++++++++++
 tb/tb_run_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_feeder.sv
`default_nettype none
// ============================================================================
// Module   : run_feeder
// Purpose  : Packs upstream tuples P-per-word and presents them to a merger
//            input through a first-word-fall-through buffer.  Each run is
//            closed with all-ones padding followed by an all-zero terminator.
// Revision : 1.0  initial release
// ============================================================================
module run_feeder #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80,
  parameter int P          = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_tuple,
  input  logic                    i_tuple_valid,
  input  logic                    i_tuple_last,
  output logic                    o_tuple_ready,
  output logic [P*DATA_WIDTH-1:0] o_data,
  output logic                    o_empty,
  input  logic                    i_read,
  output logic                    o_underrun,
  output logic                    o_zero_err
);

  localparam int C_CNT_W  = $clog2(P);
  localparam int C_PTR_W  = $clog2(DEPTH);
  localparam int C_OCC_W  = C_PTR_W + 1;
  localparam int C_WORD_W = P * DATA_WIDTH;
  localparam logic [C_CNT_W-1:0] C_LAST_LANE = C_CNT_W'(P - 1);
  localparam logic [C_OCC_W-1:0] C_FULL_OCC  = C_OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_TERM = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_lane [P];
  logic [C_WORD_W-1:0]   r_mem  [DEPTH];
  logic [C_PTR_W-1:0]    r_wr_ptr;
  logic [C_PTR_W-1:0]    r_rd_ptr;
  logic [C_OCC_W-1:0]    r_occ;
  logic                  r_underrun;
  logic                  r_zero_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_zero_tuple;
  logic [C_WORD_W-1:0]   w_push_word;
  logic [C_WORD_W-1:0]   w_fill_word;
  logic [C_WORD_W-1:0]   w_pad_word;

  // Full is taken from the registered occupancy only: a pop in the same
  // cycle does not open a slot for a push until the next cycle.
  assign w_full  = (r_occ == C_FULL_OCC);
  assign w_empty = (r_occ == '0);
  assign w_pop   = i_read & ~w_empty;

  // Ready is forced low while reset is asserted, independent of the clock.
  assign w_ready  = i_rst_n && (r_state == S_FILL) && ((r_cnt != C_LAST_LANE) || !w_full);
  assign w_accept = i_tuple_valid & w_ready;

  // The all-zero pattern is reserved for the terminator; key and payload
  // fields are checked separately so the rule stays visible per field.
  assign w_zero_tuple = (i_tuple[KEY_WIDTH-1:0] == '0) &&
                        (i_tuple[DATA_WIDTH-1:KEY_WIDTH] == '0);

  assign o_tuple_ready = w_ready;
  assign o_empty       = w_empty;
  assign o_data        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_underrun    = r_underrun;
  assign o_zero_err    = r_zero_err;

  // Candidate words: the completed word (incoming tuple in the top lane)
  // and the padded word (lanes at or above the lane count forced to ones).
  always_comb begin
    w_fill_word = '0;
    w_pad_word  = '0;
    for (int i = 0; i < P; i++) begin
      w_fill_word[i*DATA_WIDTH +: DATA_WIDTH] = (i == P - 1) ? i_tuple : r_lane[i];
      w_pad_word[i*DATA_WIDTH +: DATA_WIDTH]  = (C_CNT_W'(i) >= r_cnt) ?
                                                {DATA_WIDTH{1'b1}} : r_lane[i];
    end
  end

  // Next-state, lane count and buffer-push decision for FILL/PAD/TERM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_word = '0;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (r_cnt == C_LAST_LANE) begin
            w_push      = 1'b1;
            w_push_word = w_fill_word;
            w_cnt_nxt   = '0;
            if (i_tuple_last) w_state_nxt = S_TERM;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_W'(1);
            if (i_tuple_last) w_state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_word = w_pad_word;
          w_cnt_nxt   = '0;
          w_state_nxt = S_TERM;
        end
      end
      S_TERM: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_word = '0;
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register and lane counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + C_OCC_W'(1);
        2'b01:   r_occ <= r_occ - C_OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Sticky error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_underrun <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      if (i_read && w_empty)        r_underrun <= 1'b1;
      if (w_accept && w_zero_tuple) r_zero_err <= 1'b1;
    end
  end

  // Datapath storage: lanes and buffer entries need no reset because
  // occupancy and the lane count qualify every read of them.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_lane[r_cnt] <= i_tuple;
    if (w_push)   r_mem[r_wr_ptr] <= w_push_word;
  end

endmodule
`default_nettype wire

// File: tb/tb_run_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_feeder
// Purpose  : Self-checking bench for run_feeder (DATA_WIDTH=8, P=4, DEPTH=4)
// Revision : 1.0  initial release
// ============================================================================
module tb_run_feeder;

  localparam int DW = 8;
  localparam int KW = 4;
  localparam int P  = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tuple_in = '0;
  logic          tuple_valid = 1'b0;
  logic          tuple_last = 1'b0;
  logic          tuple_ready;
  logic [P*DW-1:0] data;
  logic          empty;
  logic          read = 1'b0;
  logic          underrun;
  logic          zero_err;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [DW-1:0]   run_q[$];
  logic [P*DW-1:0] exp_q[$];
  logic [P*DW-1:0] got_q[$];
  bit exp_zero_err = 0;
  bit exp_underrun = 0;
  logic obs_ready, obs_empty;

  run_feeder #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .P(P), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tuple(tuple_in), .i_tuple_valid(tuple_valid),
    .i_tuple_last(tuple_last), .o_tuple_ready(tuple_ready), .o_data(data),
    .o_empty(empty), .i_read(read), .o_underrun(underrun), .o_zero_err(zero_err)
  );

  always #5 clk = ~clk;

  // Model: a closed run becomes ceil(n/P) words, the last one padded with
  // all-ones tuples, followed by one all-zero terminator word.
  task automatic model_accept(input logic [DW-1:0] t, input bit l);
    int n;
    logic [P*DW-1:0] w;
    run_q.push_back(t);
    if (t == '0) exp_zero_err = 1;
    if (l) begin
      n = run_q.size();
      for (int wi = 0; wi * P < n; wi++) begin
        w = '1;
        for (int k = 0; k < P; k++)
          if (wi * P + k < n) w[k*DW +: DW] = run_q[wi*P + k];
        exp_q.push_back(w);
      end
      exp_q.push_back('0);
      run_q.delete();
    end
  endtask

  // One clock cycle of stimulus. rdm: 0 no read, 1 read, 2 read only if non-empty.
  task automatic cycle(input bit v, input logic [DW-1:0] t, input bit l, input int rdm,
                       output bit acc);
    bit rd;
    @(negedge clk);
    rd = (rdm == 1) || (rdm == 2 && !empty);
    tuple_valid = v; tuple_in = t; tuple_last = l; read = rd;
    #1;
    obs_ready = tuple_ready;
    obs_empty = empty;
    acc = v && tuple_ready;
    if (rd && !empty) got_q.push_back(data);
    if (rd && empty) exp_underrun = 1;
    if (acc) model_accept(t, l);
    @(posedge clk);
    #1;
    tuple_valid = 1'b0; tuple_last = 1'b0; read = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] t, input bit l, input int rdm, output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 20) begin
      cycle(1'b1, t, l, rdm, ok);
      n++;
    end
  endtask

  task automatic drain(output bit timeout);
    bit a;
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      cycle(1'b0, '0, 1'b0, 2, a);
      n++;
    end
    timeout = (got_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (empty !== 1'b1 || tuple_ready !== 1'b0 || data !== '0 || underrun !== 1'b0 || zero_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: empty=%b ready=%b data=%h underrun=%b zero_err=%b, want 1 0 0 0 0",
               empty, tuple_ready, data, underrun, zero_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (empty !== 1'b1 || tuple_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: empty=%b ready=%b, want 1 1", empty, tuple_ready);
    end
  endtask

  task automatic test_full_word();
    bit ok, to, e_acc;
    for (int i = 1; i <= 4; i++) feed(DW'(i), i == 4, 0, ok);
    e_acc = obs_empty;
    @(negedge clk);
    #1;
    tests_run++;
    if (e_acc !== 1'b1 || empty !== 1'b0 || data !== 32'h04030201) begin
      tests_failed++;
      $display("FAIL full_word_timing: empty_at_accept=%b empty_next=%b data=%h, want 1 0 04030201",
               e_acc, empty, data);
    end
    drain(to);
    tests_run++;
    if (to || got_q.size() != 2 || got_q[0] !== 32'h04030201 || got_q[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL full_word_data: got %0d words %p, want 04030201 00000000", got_q.size(), got_q);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial();
    bit ok, acc, to;
    bit r_pad, r_term, r_fill;
    feed(8'h05, 1'b0, 0, ok);
    feed(8'h06, 1'b1, 0, ok);
    cycle(1'b1, 8'h07, 1'b0, 0, acc); r_pad  = obs_ready;
    cycle(1'b1, 8'h07, 1'b0, 0, acc); r_term = obs_ready;
    cycle(1'b0, 8'h07, 1'b0, 0, acc); r_fill = obs_ready;
    tests_run++;
    if (r_pad !== 1'b0 || r_term !== 1'b0 || r_fill !== 1'b1) begin
      tests_failed++;
      $display("FAIL partial_ready: pad=%b term=%b fill=%b, want 0 0 1", r_pad, r_term, r_fill);
    end
    drain(to);
    tests_run++;
    if (to || got_q.size() != 2 || got_q[0] !== 32'hFFFF0605 || got_q[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL partial_data: got %0d words %p, want FFFF0605 00000000", got_q.size(), got_q);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok, acc, to, any_ready;
    logic [P*DW-1:0] head;
    for (int i = 1; i <= 19; i++) feed(DW'(i), 1'b0, 0, ok);
    any_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'd20, 1'b1, 0, acc);
      any_ready |= obs_ready;
    end
    tests_run++;
    if (any_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_stall_full: ready=%b at cnt 3 with full buffer, want 0", any_ready);
    end
    cycle(1'b1, 8'd20, 1'b1, 1, acc);
    tests_run++;
    if (acc !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_pop_no_credit: accepted=%b while full with pop, want 0", acc);
    end
    cycle(1'b1, 8'd20, 1'b1, 0, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_push_after_pop: accepted=%b cycle after pop, want 1", acc);
    end
    repeat (3) cycle(1'b0, '0, 1'b0, 0, acc);
    @(negedge clk);
    head = data;
    tests_run++;
    if (head !== 32'h08070605) begin
      tests_failed++;
      $display("FAIL bp_head_held: head=%h while terminator waits, want 08070605", head);
    end
    drain(to);
    tests_run++;
    if (to || got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL bp_word[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_push_pop();
    bit ok, acc, to, r20;
    for (int i = 1; i <= 16; i++) feed(DW'(8'h20 + i), 1'b0, (i == 16) ? 1 : 0, ok);
    for (int i = 17; i <= 19; i++) feed(DW'(8'h20 + i), 1'b0, 0, ok);
    cycle(1'b1, 8'h34, 1'b0, 0, acc);
    r20 = acc;
    tests_run++;
    if (r20 !== 1'b1) begin
      tests_failed++;
      $display("FAIL pp_occ3_stays: accepted=%b at cnt 3 after push+pop at occupancy 3, want 1", r20);
    end
    if (!acc) feed(8'h34, 1'b0, 0, ok);
    feed(8'h35, 1'b1, 2, ok);
    drain(to);
    tests_run++;
    if (to || got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL pp_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL pp_word[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    bit acc, ok, to;
    cycle(1'b0, '0, 1'b0, 1, acc);
    @(negedge clk);
    tests_run++;
    if (underrun !== 1'b1 || zero_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_underrun_set: underrun=%b zero_err=%b, want 1 0", underrun, zero_err);
    end
    feed(8'h00, 1'b1, 0, ok);
    repeat (3) cycle(1'b0, '0, 1'b0, 0, acc);
    tests_run++;
    if (underrun !== 1'b1 || zero_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: underrun=%b zero_err=%b, want 1 1", underrun, zero_err);
    end
    drain(to);
    tests_run++;
    if (to || got_q.size() != 2 || got_q[0] !== 32'hFFFFFF00 || got_q[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL err_zero_packed: got %0d words %p, want FFFFFF00 00000000", got_q.size(), got_q);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_pad();
    bit ok, to, e_before;
    for (int i = 0; i < 4; i++) feed(DW'(8'h41 + i), 1'b0, 0, ok);
    feed(8'h45, 1'b1, 0, ok);
    @(negedge clk);
    e_before = empty;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (e_before !== 1'b0 || empty !== 1'b1 || tuple_ready !== 1'b0 || underrun !== 1'b0 || zero_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_pad: empty %b->%b ready=%b underrun=%b zero_err=%b, want 0->1 0 0 0",
               e_before, empty, tuple_ready, underrun, zero_err);
    end
    run_q.delete(); exp_q.delete(); got_q.delete();
    exp_zero_err = 0; exp_underrun = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    feed(8'h51, 1'b0, 0, ok);
    feed(8'h52, 1'b1, 0, ok);
    drain(to);
    tests_run++;
    if (to || got_q.size() != 2 || got_q[0] !== 32'hFFFF5251 || got_q[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_lane0: got %0d words %p, want FFFF5251 00000000", got_q.size(), got_q);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit acc, to, have, closed, lst;
    logic [DW-1:0] tup;
    int rem, cyc;
    have = 0; closed = 1; cyc = 0; lst = 0; tup = '0;
    rem = $urandom_range(1, 10);
    while ((cyc < 600 || !closed) && cyc < 3000) begin
      if (!have) begin
        tup = DW'($urandom_range(1, 255));
        lst = (rem == 1);
        have = 1;
      end
      cycle($urandom_range(0, 9) < 7, tup, lst, ($urandom_range(0, 9) < 4) ? 2 : 0, acc);
      if (acc) begin
        have = 0;
        closed = lst;
        rem--;
        if (rem == 0) rem = $urandom_range(1, 10);
      end
      cyc++;
    end
    drain(to);
    tests_run++;
    if (to || got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rand_word[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (empty !== 1'b1 || underrun !== exp_underrun || zero_err !== exp_zero_err) begin
      tests_failed++;
      $display("FAIL rand_final: empty=%b underrun=%b zero_err=%b, want 1 %b %b",
               empty, underrun, zero_err, exp_underrun, exp_zero_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_push_pop();
    test_errors();
    test_reset_mid_pad();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
